// File: rtl/obhdr_rd_if.sv
// Phrase-read handshake between the object-header reader and the memory arbiter.
// The reader drives the request and address; the arbiter returns the ack and the phrase.
interface obhdr_rd_if;
    logic        rd_req;
    logic [20:0] rd_addr;
    logic        rd_ack;
    logic [63:0] rd_data;

    modport master (output rd_req, rd_addr, input rd_ack, rd_data);
    modport slave  (input rd_req, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/obhdr_rd.sv
// Object-header reader: fetches a 1/2/3-phrase object-list entry and holds the
// decoded bitmap / scaled-bitmap fields for the render and writeback stages.
module obhdr_rd (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [20:0]       olp,
    obhdr_rd_if.master        rd,
    output logic              busy,
    output logic              hdr_valid,
    output logic [2:0]        otype,
    output logic [10:0]       ypos,
    output logic [9:0]        height,
    output logic              heightnz,
    output logic [18:0]       link,
    output logic [20:0]       data,
    output logic [11:0]       xpos,
    output logic [2:0]        depth,
    output logic [9:0]        dwidth,
    output logic [9:0]        iwidth,
    output logic [7:0]        hscale,
    output logic [7:0]        vscale,
    output logic [7:0]        remainder,
    output logic              scaled
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, DONE} state_t;

    state_t      state_q, state_d;
    logic [20:0] base_q, base_d;
    logic [63:0] p0_q, p0_d;
    logic [14:0] p1_lo_q, p1_lo_d;   // xpos, depth
    logic [19:0] p1_hi_q, p1_hi_d;   // dwidth, iwidth
    logic [23:0] p2_q, p2_d;

    logic        rd_req_o;
    logic [20:0] rd_addr_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            p0_q    <= '0;
            p1_lo_q <= '0;
            p1_hi_q <= '0;
            p2_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            p0_q    <= p0_d;
            p1_lo_q <= p1_lo_d;
            p1_hi_q <= p1_hi_d;
            p2_q    <= p2_d;
        end
    end

    // Fields are cleared when a new fetch is accepted, so phrases the type
    // does not need read back as zero.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        p0_d    = p0_q;
        p1_lo_d = p1_lo_q;
        p1_hi_d = p1_hi_q;
        p2_d    = p2_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = olp;
                    p0_d    = '0;
                    p1_lo_d = '0;
                    p1_hi_d = '0;
                    p2_d    = '0;
                    state_d = RD0;
                end
            end
            RD0: begin
                if (rd.rd_ack) begin
                    p0_d    = rd.rd_data;
                    state_d = (rd.rd_data[2:1] == 2'b00) ? RD1 : DONE;
                end
            end
            RD1: begin
                if (rd.rd_ack) begin
                    p1_lo_d = rd.rd_data[14:0];
                    p1_hi_d = rd.rd_data[37:18];
                    state_d = (p0_q[2:0] == 3'd1) ? RD2 : DONE;
                end
            end
            RD2: begin
                if (rd.rd_ack) begin
                    p2_d    = rd.rd_data[23:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_req_o  = 1'b0;
        rd_addr_o = '0;
        busy      = 1'b0;
        hdr_valid = 1'b0;
        case (state_q)
            RD0: begin
                rd_req_o  = 1'b1;
                rd_addr_o = base_q;
                busy      = 1'b1;
            end
            RD1: begin
                rd_req_o  = 1'b1;
                rd_addr_o = base_q + 21'd1;
                busy      = 1'b1;
            end
            RD2: begin
                rd_req_o  = 1'b1;
                rd_addr_o = base_q + 21'd2;
                busy      = 1'b1;
            end
            DONE:    hdr_valid = 1'b1;
            default: ;
        endcase
    end

    assign rd.rd_req  = rd_req_o;
    assign rd.rd_addr = rd_addr_o;

    assign otype     = p0_q[2:0];
    assign ypos      = p0_q[13:3];
    assign height    = p0_q[23:14];
    assign link      = p0_q[42:24];
    assign data      = p0_q[63:43];
    assign xpos      = p1_lo_q[11:0];
    assign depth     = p1_lo_q[14:12];
    assign dwidth    = p1_hi_q[9:0];
    assign iwidth    = p1_hi_q[19:10];
    assign hscale    = p2_q[7:0];
    assign vscale    = p2_q[15:8];
    assign remainder = p2_q[23:16];
    assign heightnz  = |height;
    assign scaled    = (otype == 3'd1);

endmodule

// File: tb/tb_obhdr_rd.sv
// Directed bench for obhdr_rd: table of object entries with hand-set fields,
// ack delays and expected latency, plus mid-fetch start/reset sequences.
module tb_obhdr_rd;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [20:0] olp;
    logic        busy, hdr_valid, heightnz, scaled;
    logic [2:0]  otype, depth;
    logic [10:0] ypos;
    logic [9:0]  height, dwidth, iwidth;
    logic [18:0] link;
    logic [20:0] data;
    logic [11:0] xpos;
    logic [7:0]  hscale, vscale, remainder;

    obhdr_rd_if rd_bus ();

    obhdr_rd dut (
        .clk(clk), .reset(reset), .start(start), .olp(olp), .rd(rd_bus),
        .busy(busy), .hdr_valid(hdr_valid), .otype(otype), .ypos(ypos),
        .height(height), .heightnz(heightnz), .link(link), .data(data),
        .xpos(xpos), .depth(depth), .dwidth(dwidth), .iwidth(iwidth),
        .hscale(hscale), .vscale(vscale), .remainder(remainder), .scaled(scaled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] olp;
        int          dly;
        logic [2:0]  ty;
        logic [20:0] dat;
        logic [18:0] lnk;
        logic [9:0]  hgt;
        logic [10:0] yp;
        logic [11:0] xp;
        logic [2:0]  dep;
        logic [9:0]  dw;
        logic [9:0]  iw;
        logic [7:0]  hs;
        logic [7:0]  vs;
        logic [7:0]  rm;
        int          nreq;
        int          lat;
        logic        hnz;
        logic        scl;
    } vec_t;

    vec_t vecs[7];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_p0(input vec_t v);
        return {v.dat, v.lnk, v.hgt, v.yp, v.ty};
    endfunction

    function automatic logic [63:0] mk_p1(input vec_t v);
        return {26'h2A5A5A5, v.iw, v.dw, 3'b101, v.dep, v.xp};
    endfunction

    function automatic logic [63:0] mk_p2(input vec_t v);
        return {40'hDEADBEEF55, v.rm, v.vs, v.hs};
    endfunction

    task automatic check_fields(input string tag, input vec_t v);
        logic f1, f2;
        f1 = (v.nreq >= 2);
        f2 = (v.nreq >= 3);
        chk({tag, ".otype"},     64'(otype),     64'(v.ty));
        chk({tag, ".ypos"},      64'(ypos),      64'(v.yp));
        chk({tag, ".height"},    64'(height),    64'(v.hgt));
        chk({tag, ".heightnz"},  64'(heightnz),  64'(v.hnz));
        chk({tag, ".link"},      64'(link),      64'(v.lnk));
        chk({tag, ".data"},      64'(data),      64'(v.dat));
        chk({tag, ".xpos"},      64'(xpos),      f1 ? 64'(v.xp)  : 64'd0);
        chk({tag, ".depth"},     64'(depth),     f1 ? 64'(v.dep) : 64'd0);
        chk({tag, ".dwidth"},    64'(dwidth),    f1 ? 64'(v.dw)  : 64'd0);
        chk({tag, ".iwidth"},    64'(iwidth),    f1 ? 64'(v.iw)  : 64'd0);
        chk({tag, ".hscale"},    64'(hscale),    f2 ? 64'(v.hs)  : 64'd0);
        chk({tag, ".vscale"},    64'(vscale),    f2 ? 64'(v.vs)  : 64'd0);
        chk({tag, ".remainder"}, 64'(remainder), f2 ? 64'(v.rm)  : 64'd0);
        chk({tag, ".scaled"},    64'(scaled),    64'(v.scl));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".rd_req"},    64'(rd_bus.rd_req),  64'd0);
        chk({tag, ".rd_addr"},   64'(rd_bus.rd_addr), 64'd0);
        chk({tag, ".busy"},      64'(busy),      64'd0);
        chk({tag, ".hdr_valid"}, 64'(hdr_valid), 64'd0);
        chk({tag, ".p0fields"},  {data, link, height, ypos, otype}, 64'd0);
        chk({tag, ".p1fields"},  64'({iwidth, dwidth, depth, xpos}), 64'd0);
        chk({tag, ".p2fields"},  64'({remainder, vscale, hscale}), 64'd0);
        chk({tag, ".heightnz"},  64'(heightnz),  64'd0);
        chk({tag, ".scaled"},    64'(scaled),    64'd0);
    endtask

    task automatic run_vec(input int k);
        vec_t        v;
        logic [63:0] p[3];
        int          nseen, wcnt, cyc;
        bit          got;
        logic [20:0] exp_addr;
        string       tag;
        v = vecs[k];
        p[0] = mk_p0(v);
        p[1] = mk_p1(v);
        p[2] = mk_p2(v);
        tag = $sformatf("v%0d", k);
        nseen = 0;
        wcnt = 0;
        got = 1'b0;
        tick;
        start = 1'b1;
        olp = v.olp;
        tick;
        start = 1'b0;
        cyc = 1;
        while (cyc < 60 && !got) begin
            rd_bus.rd_ack = 1'b0;
            if (hdr_valid) begin
                got = 1'b1;
                chk({tag, ".latency"},  64'(cyc),   64'(v.lat));
                chk({tag, ".nreq"},     64'(nseen), 64'(v.nreq));
                chk({tag, ".busy_hdr"}, 64'(busy),  64'd0);
                check_fields(tag, v);
            end else begin
                if (nseen < v.nreq) begin
                    exp_addr = v.olp + 21'(nseen);
                    chk({tag, ".rd_req"},  64'(rd_bus.rd_req),  64'd1);
                    chk({tag, ".busy"},    64'(busy),           64'd1);
                    chk({tag, ".rd_addr"}, 64'(rd_bus.rd_addr), 64'(exp_addr));
                    if (wcnt == v.dly) begin
                        rd_bus.rd_ack  = 1'b1;
                        rd_bus.rd_data = p[nseen];
                        nseen++;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    chk({tag, ".extra_req"}, 64'(rd_bus.rd_req), 64'd0);
                end
                tick;
                cyc++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got no hdr_valid expected one within 60 cycles", tag);
        end else begin
            tick;
            chk({tag, ".hdr_pulse"},  64'(hdr_valid), 64'd0);
            chk({tag, ".busy_after"}, 64'(busy),      64'd0);
            chk({tag, ".hold"},       64'(height),    64'(v.hgt));
        end
    endtask

    initial begin
        vecs[0] = '{21'h000200, 2, 3'd1, 21'h0ABCD, 19'h7FFFF, 10'h3FF, 11'h7FF, 12'hFED, 3'd5,
                    10'h2AA, 10'h155, 8'h10, 8'h20, 8'h40, 3, 10, 1'b1, 1'b1};
        vecs[1] = '{21'h000100, 0, 3'd0, 21'h12345, 19'h00200, 10'h0A0, 11'h050, 12'h123, 3'd3,
                    10'h014, 10'h014, 8'hAA, 8'hBB, 8'hCC, 2, 3, 1'b1, 1'b0};
        vecs[2] = '{21'h000ABC, 0, 3'd4, 21'h1FFFF, 19'h12345, 10'h000, 11'h123, 12'h777, 3'd7,
                    10'h3FF, 10'h3FF, 8'h11, 8'h22, 8'h33, 1, 2, 1'b0, 1'b0};
        vecs[3] = '{21'h1FFFFF, 1, 3'd1, 21'h00001, 19'h00001, 10'h001, 11'h001, 12'h001, 3'd1,
                    10'h001, 10'h001, 8'h01, 8'h02, 8'h03, 3, 7, 1'b1, 1'b1};
        vecs[4] = '{21'h0F0F0F, 3, 3'd3, 21'h15555, 19'h2AAAA, 10'h155, 11'h2AA, 12'h0F0, 3'd2,
                    10'h111, 10'h222, 8'h44, 8'h55, 8'h66, 1, 5, 1'b1, 1'b0};
        vecs[5] = '{21'h012345, 0, 3'd2, 21'h00F00, 19'h0000F, 10'h200, 11'h400, 12'h800, 3'd4,
                    10'h100, 10'h080, 8'h77, 8'h88, 8'h99, 1, 2, 1'b1, 1'b0};
        vecs[6] = '{21'h1ABCDE, 1, 3'd7, 21'h1F0F0, 19'h70707, 10'h001, 11'h555, 12'hABC, 3'd6,
                    10'h0FF, 10'h0EE, 8'hDD, 8'hEE, 8'hFF, 1, 3, 1'b1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        olp = '0;
        rd_bus.rd_ack = 1'b0;
        rd_bus.rd_data = '0;
        tick;
        tick;
        reset = 1'b0;
        check_all_zero("reset");

        for (int k = 0; k < 7; k++) run_vec(k);

        // start re-pulsed in RD1 is ignored; reset in an RD2 wait aborts the fetch
        begin
            vec_t v;
            v = vecs[0];
            tick;
            start = 1'b1;
            olp = 21'h000300;
            tick;
            start = 1'b0;
            chk("abort.addr0", 64'(rd_bus.rd_addr), 64'h300);
            rd_bus.rd_ack = 1'b1;
            rd_bus.rd_data = mk_p0(v);
            tick;
            rd_bus.rd_ack = 1'b0;
            chk("abort.addr1", 64'(rd_bus.rd_addr), 64'h301);
            start = 1'b1;
            olp = 21'h000055;
            tick;
            start = 1'b0;
            chk("abort.req_held", 64'(rd_bus.rd_req),  64'd1);
            chk("abort.addr1b",   64'(rd_bus.rd_addr), 64'h301);
            rd_bus.rd_ack = 1'b1;
            rd_bus.rd_data = mk_p1(v);
            tick;
            rd_bus.rd_ack = 1'b0;
            chk("abort.addr2", 64'(rd_bus.rd_addr), 64'h302);
            tick;
            chk("abort.addr2b", 64'(rd_bus.rd_addr), 64'h302);
            reset = 1'b1;
            rd_bus.rd_ack = 1'b1;
            rd_bus.rd_data = mk_p2(v);
            tick;
            reset = 1'b0;
            rd_bus.rd_ack = 1'b0;
            check_all_zero("abort");
            for (int i = 0; i < 4; i++) begin
                tick;
                chk("abort.no_hdr", 64'(hdr_valid),     64'd0);
                chk("abort.idle",   64'(rd_bus.rd_req), 64'd0);
            end
        end

        // start during DONE is dropped and the decoded fields stay put
        begin
            vec_t v;
            v = vecs[1];
            tick;
            start = 1'b1;
            olp = v.olp;
            tick;
            start = 1'b0;
            rd_bus.rd_ack = 1'b1;
            rd_bus.rd_data = mk_p0(v);
            tick;
            rd_bus.rd_data = mk_p1(v);
            tick;
            rd_bus.rd_ack = 1'b0;
            chk("done_start.hdr", 64'(hdr_valid), 64'd1);
            start = 1'b1;
            olp = 21'h000400;
            tick;
            start = 1'b0;
            chk("done_start.busy",   64'(busy),           64'd0);
            chk("done_start.req",    64'(rd_bus.rd_req),  64'd0);
            chk("done_start.hdr2",   64'(hdr_valid),      64'd0);
            chk("done_start.height", 64'(height),         64'h0A0);
            chk("done_start.dwidth", 64'(dwidth),         64'h014);
            tick;
            chk("done_start.req2",   64'(rd_bus.rd_req),  64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obhdr_rd.md
# obhdr_rd

Object-header reader for the object processor. It runs a phrase-read handshake against the memory arbiter, fetches one object-list entry (1, 2 or 3 phrases depending on object type), and decodes the bitmap and scaled-bitmap fields. It presents the decoded fields, held stable, to the line-render and writeback stages. It is the fetch-side counterpart of the writeback block: it supplies the height, data, dwidth, vscale and remainder values that writeback later updates and stores back.

## Interface
Parameters:
- none (field positions fixed by the object-list format)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: fetch the entry at olp; ignored while busy
- olp  in  21  object-list pointer, phrase address (byte address bits 23:3)
- rd_req  out  1  phrase read request; held until rd_ack
- rd_addr  out  21  phrase address of the current request
- rd_ack  in  1  read accepted and rd_data valid this cycle
- rd_data  in  64  read phrase
- busy  out  1  high from the cycle after start until hdr_valid
- hdr_valid  out  1  one-cycle pulse: all fields valid
- otype  out  3  object type, phrase0[2:0]
- ypos  out  11  phrase0[13:3]
- height  out  10  phrase0[23:14]
- heightnz  out  1  height != 0
- link  out  19  phrase0[42:24]
- data  out  21  phrase0[63:43]
- xpos  out  12  phrase1[11:0]
- depth  out  3  phrase1[14:12]
- dwidth  out  10  phrase1[27:18]
- iwidth  out  10  phrase1[37:28]
- hscale  out  8  phrase2[7:0]
- vscale  out  8  phrase2[15:8]
- remainder  out  8  phrase2[23:16]
- scaled  out  1  otype == 1

## Operation
- States: IDLE, RD0, RD1, RD2, DONE.
- IDLE: on start, latch olp into base and go to RD0. busy rises on the next cycle.
- RDn: drive rd_req=1 and rd_addr=base+n (21-bit add, wraps modulo 2^21).
  - On rd_ack, capture rd_data into the fields of phrase n.
  - From RD0: type 0 (bitmap) or 1 (scaled) go to RD1. Any other type (2 GPU, 3 branch, 4 stop, 5-7 reserved) goes to DONE.
  - From RD1: scaled goes to RD2; bitmap goes to DONE.
  - From RD2: go to DONE.
- Without rd_ack, stay in the state. rd_req and rd_addr must not change.
- DONE: pulse hdr_valid for one cycle, drop busy, return to IDLE.
- Fields not fetched for the current type read as 0:
  - Non-bitmap types: phrase1 and phrase2 fields are 0.
  - Bitmap (type 0): hscale, vscale and remainder are 0.
- All fields hold until the next start is accepted. They are cleared when that start is accepted.
- heightnz and scaled are combinational from the registered height and otype.
- start while busy (including in DONE) is dropped, not queued. start in IDLE in the same cycle as hdr_valid cannot occur, because DONE is not IDLE.

## Timing
- Reset: state=IDLE. rd_req=0, rd_addr=0, busy=0, hdr_valid=0, all fields 0, heightnz=0, scaled=0.
- Reset asserted mid-fetch: the next cycle is IDLE with rd_req=0. A pending rd_ack in the reset cycle is ignored.
- start at cycle N gives rd_req=1 at N+1.
- rd_ack at cycle M captures data at the M edge. The next request (if any) is asserted at M+1. There are no idle cycles between phrases.
- hdr_valid occurs the cycle after the final rd_ack.
- Minimum latency with rd_ack in the same cycle as rd_req:
  - stop/branch/GPU: start N, hdr_valid N+2.
  - bitmap: hdr_valid N+3.
  - scaled: hdr_valid N+4.
- Fields are updated at each ack edge. Consumers sample them only at hdr_valid.

## Test plan
- Bitmap fetch: olp=0x000100; phrase0={data=0x12345, link=0x00200, height=0x0A0, ypos=0x050, type=0}; phrase1 dwidth=0x014, iwidth=0x014; ack every request immediately.
  -> rd_addr 0x100 then 0x101; hdr_valid at N+3; height=0x0A0, heightnz=1, scaled=0, vscale=0.
- Scaled fetch with 2-cycle ack delay per phrase; phrase2={remainder=0x40, vscale=0x20, hscale=0x10}.
  -> rd_req/rd_addr stable through each wait; three requests at base, base+1, base+2; hdr_valid at N+10; vscale=0x20, remainder=0x40, scaled=1.
- Stop object (type 4) with height=0.
  -> exactly one request; hdr_valid at N+2; dwidth=0; heightnz=0.
- Address wrap: olp=0x1FFFFF, type 1.
  -> rd_addr sequence 0x1FFFFF, 0x000000, 0x000001.
- start re-pulsed during RD1, plus reset asserted during RD2 wait.
  -> the second start is ignored; after reset, next cycle rd_req=0, busy=0, all fields 0, no hdr_valid.
